// File: rtl/stdp_pkg.sv
// ---------------------------------------------------------------------------
// stdp_pkg
// Shared definitions for the STDP synapse array:
//   - one_val / ONE   : the fixed-point value 1.0 for a given fractional width
//   - state_t         : step sequencer states
//   - saturate        : clamp a wide signed value into an n-bit signed range
//   - fxp_mul         : signed fixed-point multiply, floor shift by q, saturate
// The helpers work on 128-bit intermediates, so word widths up to 64 bits
// are supported.
// ---------------------------------------------------------------------------
package stdp_pkg;

    localparam int Q_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECAY  = 2'd1,
        SWEEP  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // 1.0 in a format with q fractional bits
    function automatic logic signed [127:0] one_val(input int q);
        return 128'sd1 <<< q;
    endfunction

    localparam logic signed [127:0] ONE = one_val(Q_DEFAULT);

    // Clamp val into [-2^(n-1), 2^(n-1)-1]
    function automatic logic signed [127:0] saturate(input logic signed [127:0] val,
                                                     input int n);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (n - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (n - 1));
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        else
            return val;
    endfunction

    // Full-precision product, arithmetic shift (floor) by q, saturate to n bits
    function automatic logic signed [127:0] fxp_mul(input logic signed [63:0] x,
                                                    input logic signed [63:0] y,
                                                    input int n,
                                                    input int q);
        logic signed [127:0] prod;
        prod = 128'(x) * 128'(y);
        return saturate(prod >>> q, n);
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// ---------------------------------------------------------------------------
// fxp_mul_sat
// Combinational saturating signed fixed-point multiplier.
//   a, b : N-bit signed operands with Q fractional bits
//   p    : floor((a*b) / 2^Q), saturated to the signed N-bit range
// ---------------------------------------------------------------------------
module fxp_mul_sat
    import stdp_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    // Operands are sign-extended into the package helper's 64-bit inputs
    always_comb begin
        p = N'(fxp_mul(64'(signed'(a)), 64'(signed'(b)), N, Q));
    end

endmodule

// File: rtl/stdp_synapse_array.sv
// ---------------------------------------------------------------------------
// stdp_synapse_array
// NUM_PRE plastic synapses converging on one postsynaptic neuron. Each apply
// runs one trace-based pair-STDP step: DECAY the post trace, SWEEP the
// channels one per cycle (weight + pre trace update), then COMMIT the post
// trace, pulse done and bump step_count.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   apply                 start a step (only accepted in IDLE)
//   pre_spikes, post_spike spike flags for the step (latched on accept)
//   a_plus, a_minus       potentiation / depression rates (latched)
//   decay                 per-step trace decay factor (latched)
//   w_min, w_max          weight bounds (latched); w_max wins if w_min > w_max
//   w_init                weight loaded into every synapse on reset
//   rd_idx / rd_weight    combinational weight readout (0 if out of range)
//   post_trace            registered postsynaptic trace
//   busy, done            step in progress / one-cycle completion pulse
//   step_count            completed steps, modulo 2^Q
//
// Build option: STDP_NEAREST_SPIKE_EN selects the nearest-spike rule (a spike
// sets its trace to 1.0); otherwise spikes add 1.0 to the decayed trace.
// ---------------------------------------------------------------------------
module stdp_synapse_array
    import stdp_pkg::*;
#(
    parameter int N       = 32,
    parameter int Q       = 16,
    parameter int NUM_PRE = 8,
    parameter int IDX_W   = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               apply,
    input  logic [NUM_PRE-1:0] pre_spikes,
    input  logic               post_spike,
    input  logic [N-1:0]       a_plus,
    input  logic [N-1:0]       a_minus,
    input  logic [N-1:0]       decay,
    input  logic [N-1:0]       w_min,
    input  logic [N-1:0]       w_max,
    input  logic [N-1:0]       w_init,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [N-1:0]       rd_weight,
    output logic [N-1:0]       post_trace,
    output logic               busy,
    output logic               done,
    output logic [Q-1:0]       step_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PRE - 1);

`ifdef STDP_NEAREST_SPIKE_EN
    localparam logic signed [N-1:0] ONE_N = N'(one_val(Q));
`else
    localparam logic signed [N+1:0] ONE_W = (N+2)'(one_val(Q));
    logic signed [N+1:0] t_sum;
    logic signed [N+1:0] p_sum;
`endif

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]    idx;
    logic signed [N-1:0] weight [NUM_PRE];
    logic signed [N-1:0] trace  [NUM_PRE];
    logic signed [N-1:0] post_tr;
    logic signed [N-1:0] pd;

    logic [NUM_PRE-1:0]  pre_l;
    logic                post_l;
    logic signed [N-1:0] a_plus_l;
    logic signed [N-1:0] a_minus_l;
    logic signed [N-1:0] decay_l;
    logic signed [N-1:0] w_min_l;
    logic signed [N-1:0] w_max_l;

    logic signed [N-1:0] mul_src;
    logic signed [N-1:0] decayed;
    logic signed [N-1:0] plus_term;
    logic signed [N-1:0] minus_term;
    logic signed [N+1:0] w_sum;
    logic signed [N-1:0] w_new;
    logic signed [N-1:0] t_new;
    logic signed [N-1:0] p_new;

    // The decay multiplier is shared: post trace during DECAY, the current
    // channel's trace during SWEEP.
    assign mul_src = (state == DECAY) ? post_tr : trace[idx];

    fxp_mul_sat #(.N(N), .Q(Q)) u_mul_decay (.a(decay_l),   .b(mul_src), .p(decayed));
    fxp_mul_sat #(.N(N), .Q(Q)) u_mul_plus  (.a(a_plus_l),  .b(decayed), .p(plus_term));
    fxp_mul_sat #(.N(N), .Q(Q)) u_mul_minus (.a(a_minus_l), .b(pd),      .p(minus_term));

    assign rd_weight  = (32'(rd_idx) < NUM_PRE) ? weight[rd_idx] : '0;
    assign post_trace = post_tr;

    // Next weight, next pre trace and next post trace. The weight sum is two
    // bits wider so potentiation and depression together cannot wrap before
    // saturation; the bounds are applied max-then-min so w_max dominates.
    always_comb begin
        w_sum = (N+2)'(weight[idx]);
        if (post_l)
            w_sum = w_sum + (N+2)'(plus_term);
        if (pre_l[idx])
            w_sum = w_sum - (N+2)'(minus_term);
        w_new = N'(saturate(128'(w_sum), N));
        if (w_new < w_min_l)
            w_new = w_min_l;
        if (w_new > w_max_l)
            w_new = w_max_l;
`ifdef STDP_NEAREST_SPIKE_EN
        t_new = pre_l[idx] ? ONE_N : decayed;
        p_new = post_l ? ONE_N : pd;
`else
        t_sum = (N+2)'(decayed);
        if (pre_l[idx])
            t_sum = t_sum + ONE_W;
        t_new = N'(saturate(128'(t_sum), N));
        p_sum = (N+2)'(pd);
        if (post_l)
            p_sum = p_sum + ONE_W;
        p_new = N'(saturate(128'(p_sum), N));
`endif
    end

    // Step sequencer state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Step sequencer next state: one DECAY cycle, NUM_PRE SWEEP cycles,
    // one COMMIT cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (apply) state_next = DECAY;
            DECAY:   state_next = SWEEP;
            SWEEP:   if (idx == LAST_IDX) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers: latch step inputs on accept, hold the decayed post
    // trace through the sweep, write one channel per SWEEP cycle and publish
    // the post trace only at COMMIT. Reset discards any partial step.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PRE; i++) begin
                weight[i] <= w_init;
                trace[i]  <= '0;
            end
            post_tr    <= '0;
            pd         <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
            pre_l      <= '0;
            post_l     <= 1'b0;
            a_plus_l   <= '0;
            a_minus_l  <= '0;
            decay_l    <= '0;
            w_min_l    <= '0;
            w_max_l    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (apply) begin
                        pre_l     <= pre_spikes;
                        post_l    <= post_spike;
                        a_plus_l  <= a_plus;
                        a_minus_l <= a_minus;
                        decay_l   <= decay;
                        w_min_l   <= w_min;
                        w_max_l   <= w_max;
                        idx       <= '0;
                        busy      <= 1'b1;
                    end
                end
                DECAY: begin
                    pd <= decayed;
                end
                SWEEP: begin
                    weight[idx] <= w_new;
                    trace[idx]  <= t_new;
                    idx         <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                COMMIT: begin
                    post_tr    <= p_new;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    step_count <= step_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/stdp_synapse_array.md
Name: stdp_synapse_array

Overview:
- Parametrised successor to the two-neuron coupled-STDP top.
- Holds NUM_PRE plastic synapses converging on one postsynaptic Izhikevich neuron, with a trace per presynaptic channel and one postsynaptic trace, all fixed-point N bits with Q fractional bits.
- Each apply pulse runs one trace-based pair-STDP step, sweeping the channels sequentially, one per cycle.
- Sits between the neuron cores (spike inputs) and the synaptic current summation (weight readout).

Parameters:
N, 32, word width of weights, traces and coefficients (signed two's complement)
Q, 16, fractional bits; ONE = 1<<Q
NUM_PRE, 8, presynaptic channel count (>=1)
IDX_W, $clog2(NUM_PRE) (min 1), channel index width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
apply  input  1  start one STDP step; sampled in IDLE only
pre_spikes  input  NUM_PRE  per-channel presynaptic spike flags for this step
post_spike  input  1  postsynaptic spike flag for this step
a_plus  input  N  potentiation rate
a_minus  input  N  depression rate
decay  input  N  per-step trace decay factor (0..ONE)
w_min  input  N  lower weight bound
w_max  input  N  upper weight bound
w_init  input  N  weight loaded into every synapse on reset
rd_idx  input  IDX_W  weight readout index
rd_weight  output  N  combinational weight[rd_idx]; 0 if rd_idx>=NUM_PRE
post_trace  output  N  registered postsynaptic trace
busy  output  1  high from the cycle after apply is accepted through COMMIT
done  output  1  one-cycle pulse at step completion
step_count  output  Q  completed steps; wraps modulo 2^Q

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset state: all weights = w_init, all pre traces = 0, post_trace = 0, busy = 0, done = 0, step_count = 0, FSM = IDLE. Reset overrides everything, including a step in progress; partial updates from that step are discarded.
- FSM: IDLE -> DECAY -> SWEEP -> COMMIT -> IDLE.
- IDLE: on apply=1, latch pre_spikes, post_spike, a_plus, a_minus, decay, w_min, w_max; set busy.
- DECAY (1 cycle): compute pd = mul(decay, post_trace) into a holding register.
- SWEEP (NUM_PRE cycles, idx 0..NUM_PRE-1): for channel i:
  - td = mul(decay, tr[i])
  - w' = w[i] + (post ? mul(a_plus, td) : 0) - (pre[i] ? mul(a_minus, pd) : 0)
  - Sum is computed N+2 wide, saturated to the signed N range, then clamped: w' = max(w', w_min), then min(w', w_max). If w_min > w_max, the result is w_max.
  - tr[i] = td + (pre[i] ? ONE : 0), saturated.
- COMMIT (1 cycle): post_trace = pd + (post ? ONE : 0), saturated; done = 1; step_count += 1; busy cleared at end.
- Coincident pre and post in the same step: both terms are applied, each using the decayed trace that excludes the current step's spikes.
- mul(x,y): signed 2N product, arithmetic shift right by Q (floor), saturate to N bits.
- Latency: done is high exactly NUM_PRE+2 clock edges after the edge that accepted apply. Back-to-back apply is accepted on the cycle after COMMIT.
- apply while busy is ignored, with no queueing.
- rd_weight during SWEEP returns the current mix of old and new weights; it is coherent only outside busy.

Optional Feature:
- Macro STDP_NEAREST_SPIKE_EN.
- Defined: nearest-spike rule; a spike sets its trace to ONE (tr = ONE, post_trace = ONE) instead of adding ONE.
- Undefined: all-to-all additive traces as specified above.

Decomposition:
- Package stdp_pkg: ONE constant, state enum typedef, saturate function, signed fixed-point multiply function.
- Sub-module fxp_mul_sat (N, Q): combinational saturating fixed-point multiply.
  - One instance for a_plus, one for a_minus, one for decay, shared between DECAY and SWEEP.

Test Plan (N=32, Q=16, NUM_PRE=4, decay=0x8000, a_plus=0x1000, a_minus=0x0800, w_min=0, w_max=0x20000):
1. reset with w_init=0x8000 -> all rd_weight=0x8000, post_trace=0, busy=0, step_count=0.
2. Step with pre_spikes=0001, post=0 -> w0 stays 0x8000. Next step with pre=0000, post=1 -> w0=0x8800, w1..w3 stay 0x8000, post_trace=0x10000.
3. Third step with pre=0001, post=0 -> pd=0x8000, w0=0x8400, post_trace=0x8000, step_count=3.
4. w_max=0x8200 repeating step 2 -> w0 clamps to 0x8200. w_min=w_max+1 -> weight forced to w_max.
5. apply held high for 10 cycles -> done pulses at edge 6 after acceptance, a second step is accepted only after COMMIT, and busy is never re-asserted mid-step.
6. reset asserted during SWEEP at idx=2 -> next cycle all weights = w_init, traces 0, no done pulse. With STDP_NEAREST_SPIKE_EN, two consecutive pre spikes -> tr0=0x10000, not 0x18000.
